harris_response_pipe: RTL

- Pipelined, parametrised Harris corner-response unit.
- Consumes one (lgxx, lgxy, lgyy) smoothed-gradient triple per accepted transfer. Computes cim = a*c - b*b - ((a+c)^2 >>> K_SHIFT), where a, b, c are the inputs arithmetically shifted right by PRE_SHIFT.
- Emits cim, a signed threshold flag and a running corner count.
- Sits between the gradient-smoothing stage and non-max suppression. Uses valid/ready handshakes on both sides.

---
 rtl/harris_response_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/harris_response_pipe.sv
// harris_response_pipe
//   Three-stage pipelined Harris corner response:
//     cim = a*c - b*b - ((a+c)^2 >>> K_SHIFT)
//   where a, b, c are the smoothed gradients arithmetically shifted right by
//   PRE_SHIFT. All arithmetic wraps modulo 2^W. A signed threshold flag and a
//   saturating count of emitted corners accompany each result.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input handshake (in_ready is the global advance enable)
//   in_lgxx/lgxy/lgyy signed smoothed gradient triple
//   thresh            signed threshold, captured as the result enters stage 3
//   cnt_clear         synchronous clear of corner_count (wins over increment)
//   out_valid/ready   output handshake
//   out_cim           signed corner response
//   out_corner        out_cim > thresh (signed, strict)
//   corner_count      saturating count of transferred results with out_corner=1
module harris_response_pipe #(
  parameter int W         = 16,
  parameter int PRE_SHIFT = 6,
  parameter int K_SHIFT   = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_lgxx,
  input  logic [W-1:0]     in_lgxy,
  input  logic [W-1:0]     in_lgyy,
  input  logic [W-1:0]     thresh,
  input  logic             cnt_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_cim,
  output logic             out_corner,
  output logic [CNT_W-1:0] corner_count
);

  // Single advance enable for every stage: the whole pipe moves together,
  // and stage 3 refills in the same cycle its result is consumed.
  logic adv;
  logic take;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign take     = in_valid && adv;

  // Stage 1 operands
  logic signed [W-1:0] sa, sb, sc;
  logic signed [W-1:0] a1, b1, c1, t1;
  logic                v1;

  // Stage 2 products
  logic [W-1:0] p2, q2, r2;
  logic         v2;

  // Stage 3 combinational result
  logic signed [W-1:0] r_sh;
  logic [W-1:0]        cim_d;
  logic                corner_d;

  always_comb begin
    sa = $signed(in_lgxx) >>> PRE_SHIFT;
    sb = $signed(in_lgxy) >>> PRE_SHIFT;
    sc = $signed(in_lgyy) >>> PRE_SHIFT;
  end

  always_comb begin
    r_sh     = $signed(r2) >>> K_SHIFT;
    cim_d    = p2 - q2 - r_sh;
    corner_d = $signed(cim_d) > $signed(thresh);
  end

  // Data registers carry no reset; only the valids and outputs do.
  always_ff @(posedge clk) begin
    if (take) begin
      a1 <= sa;
      b1 <= sb;
      c1 <= sc;
      t1 <= sa + sc;
    end
    if (adv) begin
      p2 <= a1 * c1;
      q2 <= b1 * b1;
      r2 <= t1 * t1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      out_cim    <= '0;
      out_corner <= 1'b0;
    end else if (adv) begin
      v1         <= in_valid;
      v2         <= v1;
      out_valid  <= v2;
      out_cim    <= cim_d;
      out_corner <= corner_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corner_count <= '0;
    end else if (cnt_clear) begin
      corner_count <= '0;
    end else if (out_valid && out_ready && out_corner && !(&corner_count)) begin
      corner_count <= corner_count + CNT_W'(1);
    end
  end

endmodule
